load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the execute stage and data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        misaligned
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;
  logic [3:0]  dmem_be_q;
  logic        wb_valid_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        ld_q;
  size_t       ld_size_q;
  logic        ld_unsigned_q;
  logic [1:0]  ld_off_q;
  logic [4:0]  rd_q;

  logic        is_mem;
  logic        trap_d;
  size_t       size_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_data_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign is_mem = mem_read | mem_write;

  // 100/101 are only meaningful for loads; a store with those codes is a word store.
  always_comb begin
    size_d = SZ_WORD;
    case (funct3)
      3'b000:  size_d = SZ_BYTE;
      3'b001:  size_d = SZ_HALF;
      3'b100:  size_d = mem_read ? SZ_BYTE : SZ_WORD;
      3'b101:  size_d = mem_read ? SZ_HALF : SZ_WORD;
      default: size_d = SZ_WORD;
    endcase
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data;
    case (size_d)
      SZ_BYTE: begin
        be_d    = 4'b0001 << alu_result[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        be_d    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_d = ((size_d == SZ_HALF) && alu_result[0]) ||
                  ((size_d == SZ_WORD) && (alu_result[1:0] != 2'b00));
`else
  assign trap_d = 1'b0;
`endif

  always_comb begin
    ld_byte     = dmem_rdata[{ld_off_q, 3'b000} +: 8];
    ld_half     = ld_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data_d = dmem_rdata;
    case (ld_size_q)
      SZ_BYTE: load_data_d = {{24{ld_byte[7] & ~ld_unsigned_q}}, ld_byte};
      SZ_HALF: load_data_d = {{16{ld_half[15] & ~ld_unsigned_q}}, ld_half};
      default: load_data_d = dmem_rdata;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_q;
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      dmem_be_q     <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      ld_q          <= 1'b0;
      ld_size_q     <= SZ_WORD;
      ld_unsigned_q <= 1'b0;
      ld_off_q      <= '0;
      rd_q          <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_q  <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= alu_result;
              wb_rd_q    <= rd;
            end else if (trap_d) begin
`ifdef LSU_MISALIGN_TRAP_EN
              misaligned_q <= 1'b1;
`endif
            end else begin
              state_q       <= S_WAIT;
              dmem_req_q    <= 1'b1;
              dmem_we_q     <= ~mem_read;
              dmem_addr_q   <= {alu_result[31:2], 2'b00};
              dmem_wdata_q  <= wdata_d;
              dmem_be_q     <= be_d;
              ld_q          <= mem_read;
              ld_size_q     <= size_d;
              ld_unsigned_q <= funct3[2];
              ld_off_q      <= alu_result[1:0];
              rd_q          <= rd;
            end
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            state_q    <= S_IDLE;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (ld_q) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= load_data_d;
              wb_rd_q    <= rd_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ex_ready   = (state_q == S_IDLE);
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_be    = dmem_be_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_rd      = wb_rd_q;
endmodule
